calc_result_display: RTL and testbench

CALC_RESULT_DISPLAY -- requirements
Module: calc_result_display

---
 rtl/calc_result_display_if.sv | 16 +
 rtl/calc_result_display.sv | 130 +++++++++++++
 tb/tb_calc_result_display.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/calc_result_display_if.sv
// ---------------------------------------------------------------------------
// calc_result_display_if
// Purpose : valid/ready handshake carrying one adder result into the
//           calc_result_display converter.
// Signals : in_valid  producer -> display  result on in_sum is new
//           in_sum    producer -> display  unsigned result 0..31
//           in_ready  display  -> producer converter is idle and can accept
// ---------------------------------------------------------------------------
interface calc_result_display_if;
   logic       in_valid;
   logic [4:0] in_sum;
   logic       in_ready;

   modport master (output in_valid, output in_sum, input in_ready);
   modport slave  (input in_valid, input in_sum, output in_ready);
endinterface

// File: rtl/calc_result_display.sv
// ---------------------------------------------------------------------------
// calc_result_display
// Purpose : converts a 5-bit adder result to two BCD digits (double dabble,
//           one step per cycle) and drives a multiplexed two-digit
//           seven-segment display.
// Ports   : clk      single clock, rising edge
//           rst      synchronous active-high reset
//           bus      calc_result_display_if.slave (in_valid/in_sum/in_ready)
//           seg      segments g..a, active-high, from the selected digit
//           dig_sel  one-hot digit enable, 01 = ones, 10 = tens
//           busy     conversion in progress (inverse of in_ready)
// Config  : define CALC_DISP_LZB_EN to blank a leading zero in the tens slot.
// ---------------------------------------------------------------------------
module calc_result_display #(
   parameter int unsigned REFRESH_BITS = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   calc_result_display_if.slave  bus,
   output logic [6:0]            seg,
   output logic [1:0]            dig_sel,
   output logic                  busy
);

   localparam int unsigned CNT_W   = 3;
   localparam int unsigned LAST_STEP = 4;

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   state_t                  r_state, w_state_nxt;
   logic [4:0]              r_bin,   w_bin_nxt;
   logic [5:0]              r_bcd,   w_bcd_nxt;   // {tens[1:0], ones[3:0]}
   logic [CNT_W-1:0]        r_cnt,   w_cnt_nxt;
   logic [1:0]              r_tens,  w_tens_nxt;
   logic [3:0]              r_ones,  w_ones_nxt;
   logic [REFRESH_BITS-1:0] r_refresh;
   logic                    r_dig_tens;
   logic [3:0]              w_ones_adj;
   logic [3:0]              w_digit;

   // Add-3 correction on the ones nibble; tens never exceeds 3 for a 5-bit
   // input, so it never needs correcting and its MSB is zero before every shift.
   always_comb begin
      w_ones_adj = r_bcd[3:0];
      if (r_bcd[3:0] >= 4'd5) w_ones_adj = r_bcd[3:0] + 4'd3;
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_bin_nxt   = r_bin;
      w_bcd_nxt   = r_bcd;
      w_cnt_nxt   = r_cnt;
      w_tens_nxt  = r_tens;
      w_ones_nxt  = r_ones;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_bin_nxt   = bus.in_sum;
               w_bcd_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = CONV;
            end
         end
         CONV: begin
            w_bcd_nxt = {r_bcd[4], w_ones_adj, r_bin[4]};
            w_bin_nxt = {r_bin[3:0], 1'b0};
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(LAST_STEP)) w_state_nxt = LOAD;
         end
         LOAD: begin
            w_tens_nxt  = r_bcd[5:4];
            w_ones_nxt  = r_bcd[3:0];
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, scratch, display and refresh registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_tens     <= '0;
         r_ones     <= '0;
         r_refresh  <= '0;
         r_dig_tens <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_bin      <= w_bin_nxt;
         r_bcd      <= w_bcd_nxt;
         r_cnt      <= w_cnt_nxt;
         r_tens     <= w_tens_nxt;
         r_ones     <= w_ones_nxt;
         r_refresh  <= r_refresh + REFRESH_BITS'(1);
         if (&r_refresh) r_dig_tens <= ~r_dig_tens;
      end
   end

   assign bus.in_ready = (r_state == IDLE);
   assign busy         = (r_state != IDLE);
   assign dig_sel      = r_dig_tens ? 2'b10 : 2'b01;
   assign w_digit      = r_dig_tens ? {2'b00, r_tens} : r_ones;

   // Seven-segment decode of the currently selected digit
   always_comb begin
      seg = 7'b0000000;
      case (w_digit)
         4'd0: seg = 7'b0111111;
         4'd1: seg = 7'b0000110;
         4'd2: seg = 7'b1011011;
         4'd3: seg = 7'b1001111;
         4'd4: seg = 7'b1100110;
         4'd5: seg = 7'b1101101;
         4'd6: seg = 7'b1111101;
         4'd7: seg = 7'b0000111;
         4'd8: seg = 7'b1111111;
         4'd9: seg = 7'b1101111;
         default: seg = 7'b0000000;
      endcase
`ifdef CALC_DISP_LZB_EN
      if (r_dig_tens && (r_tens == 2'd0)) seg = 7'b0000000;
`else
`endif
   end

endmodule

// File: tb/tb_calc_result_display.sv
// ---------------------------------------------------------------------------
// tb_calc_result_display
// Purpose : self-checking bench for calc_result_display with a fast refresh
//           (REFRESH_BITS = 2). Expected digits come from sum/10 and sum%10,
//           expected digit slot from the number of cycles since reset.
// ---------------------------------------------------------------------------
module tb_calc_result_display;

   localparam int unsigned RB = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg;
   logic [1:0] dig_sel;
   logic       busy;

   calc_result_display_if bus_if();

   calc_result_display #(.REFRESH_BITS(RB)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if),
      .seg     (seg),
      .dig_sel (dig_sel),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // cycles elapsed since the last edge at which reset was sampled high
   int k = 0;
   always @(posedge clk) begin
      if (rst) k <= 0;
      else     k <= k + 1;
   end

   int checks   = 0;
   int failures = 0;
   int exp_val  = 0;

   localparam logic [6:0] SEG_TAB [10] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] exp_seg_f(input int val, input bit tens_slot);
      int d;
      d = tens_slot ? (val / 10) : (val % 10);
`ifdef CALC_DISP_LZB_EN
      if (tens_slot && d == 0) return 7'b0000000;
`endif
      return SEG_TAB[d];
   endfunction

   // Walk n cycles of the refresh, checking slot and segments each cycle
   task automatic check_display(input string tag, input int n);
      bit tslot;
      for (int i = 0; i < n; i++) begin
         tslot = ((k >> RB) & 1) != 0;
         chk({tag, "_dig"}, 8'(dig_sel), tslot ? 8'h02 : 8'h01);
         chk({tag, "_seg"}, 8'(seg), 8'(exp_seg_f(exp_val, tslot)));
         step();
      end
   endtask

   // mode 0: plain conversion; 1: in_valid=25 at N+3 (ignored); 2: rst at N+3
   task automatic run_conv(input int sum, input int mode, input string tag);
      bit aborted;
      aborted = 1'b0;
      chk({tag, "_ready_pre"}, 8'(bus_if.in_ready), 8'h01);
      bus_if.in_valid = 1'b1;
      bus_if.in_sum   = 5'(sum);
      step();                                      // edge N
      bus_if.in_valid = 1'b0;
      chk({tag, "_busy_N"}, 8'(busy), 8'h01);
      for (int e = 1; e <= 6; e++) begin
         if (mode == 1 && e == 3) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_sum   = 5'd25;
         end else begin
            bus_if.in_valid = 1'b0;
         end
         if (mode == 2 && e == 3) rst = 1'b1;
         step();
         if (mode == 2 && e == 3) begin
            rst     = 1'b0;
            aborted = 1'b1;
            exp_val = 0;
            chk({tag, "_rst_ready"}, 8'(bus_if.in_ready), 8'h01);
            chk({tag, "_rst_busy"}, 8'(busy), 8'h00);
         end else if (!aborted) begin
            chk({tag, "_busy"}, 8'(busy), (e < 6) ? 8'h01 : 8'h00);
            chk({tag, "_ready"}, 8'(bus_if.in_ready), (e < 6) ? 8'h00 : 8'h01);
         end
      end
      bus_if.in_valid = 1'b0;
      if (!aborted) exp_val = sum;
      check_display(tag, 8);
   endtask

   initial begin
      rst             = 1'b1;
      bus_if.in_valid = 1'b0;
      bus_if.in_sum   = 5'd0;
      step();
      step();
      rst = 1'b0;
      chk("reset_ready", 8'(bus_if.in_ready), 8'h01);
      chk("reset_busy", 8'(busy), 8'h00);
      chk("reset_dig", 8'(dig_sel), 8'h01);
      chk("reset_seg", 8'(seg), 8'h3f);
      check_display("refresh", 8);

      run_conv(23, 0, "sum23");
      run_conv(31, 0, "sum31");
      run_conv(0,  0, "sum0");
      run_conv(7,  0, "sum7");
      run_conv(10, 0, "sum10");
      for (int i = 0; i < 6; i++) run_conv(int'($urandom_range(0, 31)), 0, "rand");
      run_conv(12, 1, "ignore25");
      run_conv(19, 2, "rst_mid19");

      // reset wins over a simultaneous handshake
      rst             = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.in_sum   = 5'd9;
      step();
      rst             = 1'b0;
      bus_if.in_valid = 1'b0;
      exp_val         = 0;
      chk("rst_prio_ready", 8'(bus_if.in_ready), 8'h01);
      chk("rst_prio_busy", 8'(busy), 8'h00);
      check_display("rst_prio", 8);
      chk("rst_prio_busy_late", 8'(busy), 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
